inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set fetch queue entries (power of two, 2..8).
REQ-002 Parameter NOP_INST, default 32'h00000013, SHALL be the value driven on inst_o when no instruction is valid.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 pc_i  input  32  SHALL carry the fetch address from the PC register.
REQ-006 pc_valid_i  input  1  SHALL mark pc_i as a valid fetch request.
REQ-007 pc_ready_o  output  1  SHALL indicate that pc_i is accepted this cycle; upstream holds the PC while this is low.
REQ-008 imem_req_o  output  1  SHALL be the instruction memory request.
REQ-009 imem_addr_o  output  32  SHALL be the instruction memory word address.
REQ-010 imem_rdata_i  input  32  SHALL be the instruction memory read data; valid with imem_ack_i.
REQ-011 imem_ack_i  input  1  SHALL mark completion of the outstanding request.
REQ-012 flush_i  input  1  SHALL discard all queued and in-flight fetches (branch/jump redirect).
REQ-013 id_ready_i  input  1  SHALL indicate that decode consumes inst_o this cycle.
REQ-014 inst_o  output  32  SHALL be the queue-head instruction.
REQ-015 inst_pc_o  output  32  SHALL be the queue-head fetch address.
REQ-016 inst_valid_o  output  1  SHALL mark inst_o and inst_pc_o as valid.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and DRAIN.
REQ-018 pc_ready_o SHALL be (state==IDLE) & ~full & ~flush_i, where full means count==DEPTH.
REQ-019 In IDLE with pc_valid_i & pc_ready_o, the block SHALL register imem_addr_o=pc_i and assert imem_req_o from the next cycle, entering REQ.
REQ-020 In REQ, imem_req_o and imem_addr_o SHALL hold stable until imem_ack_i.
REQ-021 In REQ on imem_ack_i without flush_i, {imem_addr_o, imem_rdata_i} SHALL be pushed and state SHALL return to IDLE, with imem_req_o low next cycle.
REQ-022 At most one memory request SHALL be outstanding; the ack-to-next-request latency SHALL be at least one cycle.
REQ-023 flush_i in REQ without ack SHALL enter DRAIN; DRAIN SHALL keep imem_req_o high until imem_ack_i, discard that data, then enter IDLE.
REQ-024 flush_i coincident with imem_ack_i SHALL discard the data and enter IDLE.
REQ-025 flush_i SHALL clear the queue (count=0) on the next edge, overriding any same-cycle push or pop.
REQ-026 inst_valid_o SHALL equal (count!=0); when invalid, inst_o SHALL equal NOP_INST and inst_pc_o SHALL be 0.
REQ-027 A pop SHALL occur on inst_valid_o & id_ready_i; a simultaneous push and pop SHALL leave count unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide and never exceed DEPTH.
REQ-029 The queue SHALL return entries in FIFO order.

Reset
REQ-030 On rst, state SHALL be IDLE, count/pointers 0, imem_req_o 0, imem_addr_o 0, inst_valid_o 0, inst_o NOP_INST, inst_pc_o 0.
REQ-031 Reset asserted mid-request SHALL abandon the request; an ack arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-032 With IF_BYPASS_EN defined, in the REQ-state ack cycle with an empty queue and no flush, inst_o/inst_pc_o/inst_valid_o SHALL forward imem_rdata_i/imem_addr_o combinationally, and the entry SHALL not be pushed if id_ready_i is high.
REQ-033 Without IF_BYPASS_EN, inst_valid_o SHALL rise exactly one cycle after the accepting imem_ack_i.

Verification
REQ-034 Reset, pc_i=0 valid, ack 2 cycles later with rdata=0x00500093 -> inst_valid_o next cycle, inst_o=0x00500093, inst_pc_o=0.
REQ-035 id_ready_i=0, DEPTH=2, fetch 0x0,0x4 -> pc_ready_o=0 at 0x8 until one pop, then 0x8 accepted.
REQ-036 flush_i during REQ for 0xC, ack 3 cycles later -> data dropped, inst_valid_o=0, imem_req_o low after ack, next pc_i=0x40 fetched.
REQ-037 Queue holds one entry, push and pop same cycle -> count stays 1, order 0x4 then 0x8.
REQ-038 rst pulsed while in REQ -> imem_req_o=0 immediately, late ack ignored, inst_valid_o stays 0.
REQ-039 IF_BYPASS_EN defined, empty queue, ack with id_ready_i=1 -> inst_valid_o=1 in the ack cycle, count remains 0.

Source files
------------

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: PC-in, instruction-memory and decode-side handshake bundle of inst_fetch.
// master is the fetch block's view; slave is the surrounding pipeline and memory.
interface inst_fetch_if;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ack_i;
    logic        flush_i;
    logic        id_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    modport master (
        input  pc_i, pc_valid_i, imem_rdata_i, imem_ack_i, flush_i, id_ready_i,
        output pc_ready_o, imem_req_o, imem_addr_o, inst_o, inst_pc_o, inst_valid_o
    );
    modport slave (
        output pc_i, pc_valid_i, imem_rdata_i, imem_ack_i, flush_i, id_ready_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, inst_o, inst_pc_o, inst_valid_o
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with a DEPTH-entry FIFO toward decode.
// Define IF_BYPASS_EN to forward ack data straight to decode when the queue is empty.
module inst_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input logic         clk,
    input logic         rst,
    inst_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;
    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic          full, accept, ack_ok, byp, push, pop, has_entry;
    assign full      = count_q == (AW+1)'(DEPTH);
    assign has_entry = count_q != '0;
    assign bus.pc_ready_o = state_q == IDLE && !full && !bus.flush_i;
    assign accept    = bus.pc_valid_i && bus.pc_ready_o;
    assign ack_ok    = state_q == REQ && bus.imem_ack_i && !bus.flush_i;
`ifdef IF_BYPASS_EN
    assign byp = ack_ok && !has_entry;
`else
    assign byp = 1'b0;
`endif
    // A bypassed word consumed by decode in its ack cycle never enters the queue.
    assign push = ack_ok && !(byp && bus.id_ready_i);
    assign pop  = has_entry && bus.id_ready_i;
    assign bus.imem_req_o   = state_q != IDLE;
    assign bus.imem_addr_o  = addr_q;
    assign bus.inst_valid_o = has_entry || byp;
    assign bus.inst_o    = byp ? bus.imem_rdata_i : has_entry ? data_mem[rptr_q] : NOP_INST;
    assign bus.inst_pc_o = byp ? addr_q : has_entry ? pc_mem[rptr_q] : 32'h0;
    always_comb begin
        state_d = state_q;
        addr_d  = accept ? bus.pc_i : addr_q;
        case (state_q)
            IDLE:    state_d = accept ? REQ : IDLE;
            REQ:     state_d = bus.imem_ack_i ? IDLE : bus.flush_i ? DRAIN : REQ;
            DRAIN:   state_d = bus.imem_ack_i ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        count_d = bus.flush_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        wptr_d  = bus.flush_i ? '0 : push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = bus.flush_i ? '0 : pop ? rptr_q + AW'(1) : rptr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= bus.imem_rdata_i;
            pc_mem[wptr_q]   <= addr_q;
        end
    end
endmodule
